rtc_bus_arbiter_mux: RTL and testbench

Parametrised, registered N-channel arbiter and data multiplexer for the RTC datapath. Arbitrates between CHANNELS requesters (e.g. user-edit logic, periodic RTC read, display refresh), holds a grant until the owner releases it or a timeout fires, and forwards the owner's WIDTH-bit word to a single registered output. It replaces the fixed 3-input combinational priority select in front of the RTC bus interface.

---
 rtl/rtc_bus_arbiter_mux.sv | 178 +++++++++++++++++
 tb/tb_rtc_bus_arbiter_mux.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_arbiter_mux.sv
// ============================================================================
// Module   : rtc_bus_arbiter_mux
// Brief    : Registered N-channel grant-hold arbiter and word mux for the RTC
//            bus. Fixed lowest-index priority by default; round-robin when
//            RTC_ARB_ROUND_ROBIN_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_bus_arbiter_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 3,
    parameter int TIMEOUT  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       req,
    input  logic [CHANNELS-1:0]       done,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    output logic [CHANNELS-1:0]       grant,
    output logic [WIDTH-1:0]          data_out,
    output logic                      busy,
    output logic                      timeout
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]          state_q,    state_d;
    logic [CHANNELS-1:0] grant_q,    grant_d;
    logic [WIDTH-1:0]    data_out_q, data_out_d;
    logic                busy_q,     busy_d;
    logic                timeout_q,  timeout_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;

    logic                win_valid;
    logic [IDX_W-1:0]    win_idx;
    logic                owner_release;
    logic [WIDTH-1:0]    owner_data;
    logic [WIDTH-1:0]    masked_data [CHANNELS];

    // One-hot grant doubles as the owner select, so no index decode is needed.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_mask
            assign masked_data[gi] = data_in[gi*WIDTH +: WIDTH] & {WIDTH{grant_q[gi]}};
        end
    endgenerate

    always_comb begin
        owner_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            owner_data = owner_data | masked_data[i];
        end
    end

    assign owner_release = (|(done & grant_q)) || !(|(req & grant_q));

`ifdef RTC_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last_q, last_d;

    // Search descends so the nearest channel after last owner wins.
    always_comb begin
        int j;
        j         = 0;
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = CHANNELS; k >= 1; k--) begin
            j = int'(last_q) + k;
            if (j >= CHANNELS) begin
                j = j - CHANNELS;
            end
            if (req[j]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (state_q == ST_IDLE && win_valid) begin
            last_d = win_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= IDX_W'(CHANNELS - 1);
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        data_out_d = data_out_q;
        busy_d     = busy_q;
        timeout_d  = 1'b0;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                grant_d = '0;
                busy_d  = 1'b0;
                if (win_valid) begin
                    state_d = ST_GRANT;
                    grant_d = CHANNELS'(1) << win_idx;
                    busy_d  = 1'b1;
                end
            end
            ST_GRANT: begin
                data_out_d = owner_data;
                // A release wins over a coincident timeout, so no pulse then.
                if (owner_release) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
        end
    end

    assign grant    = grant_q;
    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign timeout  = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_rtc_bus_arbiter_mux.sv
// ============================================================================
// Module   : tb_rtc_bus_arbiter_mux
// Brief    : Directed self-checking bench for rtc_bus_arbiter_mux
//            (WIDTH=8, CHANNELS=3, TIMEOUT=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rtc_bus_arbiter_mux;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 3;
    localparam int TIMEOUT  = 4;

    logic                      clk;
    logic                      reset;
    logic [CHANNELS-1:0]       req;
    logic [CHANNELS-1:0]       done;
    logic [CHANNELS*WIDTH-1:0] data_in;
    logic [CHANNELS-1:0]       grant;
    logic [WIDTH-1:0]          data_out;
    logic                      busy;
    logic                      timeout;

    int checks;
    int errors;

    rtc_bus_arbiter_mux #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .done     (done),
        .data_in  (data_in),
        .grant    (grant),
        .data_out (data_out),
        .busy     (busy),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        req     = 3'b111;
        done    = 3'b000;
        data_in = {8'hAA, 8'hBB, 8'hCC};
        tick();
        tick();
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant got=%b exp=%b", grant, 3'b000); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=%h", data_out, 8'h00); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        reset = 1'b0;
        req   = 3'b000;
        tick();
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL idle_grant got=%b exp=%b", grant, 3'b000); end
    endtask

    task automatic test_priority();
        data_in = {8'hC3, 8'h5A, 8'h11};
        req     = 3'b110;
        tick();
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL prio_grant got=%b exp=%b", grant, 3'b010); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL prio_busy got=%b exp=1", busy); end
        tick();
        checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL prio_data1 got=%h exp=%h", data_out, 8'h5A); end
        done = 3'b010;
        req  = 3'b100;
        tick();
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL prio_release got=%b exp=%b", grant, 3'b000); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_rel_busy got=%b exp=0", busy); end
        done = 3'b000;
        tick();
        checks++; if (grant !== 3'b100) begin errors++; $display("FAIL prio_grant2 got=%b exp=%b", grant, 3'b100); end
        checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL prio_data_hold got=%h exp=%h", data_out, 8'h5A); end
        tick();
        checks++; if (data_out !== 8'hC3) begin errors++; $display("FAIL prio_data2 got=%h exp=%h", data_out, 8'hC3); end
        req = 3'b000;
        tick();
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL prio_req_drop got=%b exp=%b", grant, 3'b000); end
        tick();
        checks++; if (data_out !== 8'hC3) begin errors++; $display("FAIL idle_data_hold got=%h exp=%h", data_out, 8'hC3); end
    endtask

    task automatic test_timeout();
        data_in = {8'h00, 8'h00, 8'h33};
        req     = 3'b001;
        for (int i = 0; i < TIMEOUT; i++) begin
            tick();
            checks++; if (grant !== 3'b001) begin errors++; $display("FAIL to_hold[%0d] got=%b exp=%b", i, grant, 3'b001); end
            checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_early[%0d] got=%b exp=0", i, timeout); end
        end
        tick();
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL to_revoke got=%b exp=%b", grant, 3'b000); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse got=%b exp=1", timeout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy got=%b exp=0", busy); end
        tick();
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_len got=%b exp=0", timeout); end
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL to_regrant got=%b exp=%b", grant, 3'b001); end
    endtask

    // Continues from the re-grant of channel 0 left by test_timeout.
    task automatic test_non_owner_done();
        done = 3'b110;
        tick();
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL nod_grant got=%b exp=%b", grant, 3'b001); end
        done = 3'b000;
        tick();
        tick();
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL nod_hold got=%b exp=%b", grant, 3'b001); end
        done = 3'b001;
        tick();
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reltout_grant got=%b exp=%b", grant, 3'b000); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reltout_pulse got=%b exp=0", timeout); end
        done = 3'b000;
        req  = 3'b000;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reltout_busy got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [CHANNELS-1:0] exp_seq [4];
`ifdef RTC_ARB_ROUND_ROBIN_EN
        exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100; exp_seq[3] = 3'b001;
`else
        exp_seq[0] = 3'b001; exp_seq[1] = 3'b001; exp_seq[2] = 3'b001; exp_seq[3] = 3'b001;
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req   = 3'b111;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (grant !== exp_seq[i]) begin errors++; $display("FAIL b2b_grant[%0d] got=%b exp=%b", i, grant, exp_seq[i]); end
            done = exp_seq[i];
            tick();
            checks++; if (grant !== 3'b000) begin errors++; $display("FAIL b2b_gap[%0d] got=%b exp=%b", i, grant, 3'b000); end
            done = 3'b000;
        end
        req = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_grant();
        data_in = {8'h77, 8'h00, 8'h00};
        req     = 3'b100;
        tick();
        tick();
        tick();
        checks++; if (grant !== 3'b100) begin errors++; $display("FAIL mid_pre got=%b exp=%b", grant, 3'b100); end
        reset = 1'b1;
        tick();
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL mid_grant got=%b exp=%b", grant, 3'b000); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL mid_timeout got=%b exp=0", timeout); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL mid_data got=%h exp=%h", data_out, 8'h00); end
        reset = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            tick();
            checks++; if (grant !== 3'b100) begin errors++; $display("FAIL mid_budget[%0d] got=%b exp=%b", i, grant, 3'b100); end
        end
        tick();
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL mid_revoke got=%b exp=%b", grant, 3'b000); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL mid_pulse got=%b exp=1", timeout); end
        req = 3'b000;
        tick();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        req     = '0;
        done    = '0;
        data_in = '0;
        @(negedge clk);
        test_reset();
        test_priority();
        test_timeout();
        test_non_owner_done();
        test_back_to_back();
        test_reset_mid_grant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
